// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared types and defaults for the MEM pipeline stage: the
//               access FSM state type, default timing/address parameters,
//               data-memory geometry and the word-index helper.
// Contents    : mem_state_t, WAIT_CYCLES_DEFAULT, DMEM_BASE_DEFAULT,
//               DMEM_DEPTH, DMEM_AW, CNT_W, word_index()
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int WAIT_CYCLES_DEFAULT = 4;
  localparam int DMEM_BASE_DEFAULT   = 1024;
  localparam int DMEM_DEPTH          = 64;
  localparam int DMEM_AW             = $clog2(DMEM_DEPTH);
  // Wide enough for the largest legal WAIT_CYCLES (15).
  localparam int CNT_W               = 4;

  // Word index = (addr - base)[7:2]. Only the low byte of either operand can
  // influence those result bits, so the subtraction is done on bits [7:2]
  // directly, with the borrow out of bits [1:0] folded in.
  function automatic logic [DMEM_AW-1:0] word_index(
    input logic [7:0] addr_lo,
    input logic [7:0] base_lo
  );
    logic borrow;
    borrow = (addr_lo[1:0] < base_lo[1:0]);
    return addr_lo[7:2] - base_lo[7:2] - {{(DMEM_AW-1){1'b0}}, borrow};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : DEPTH x DW data memory. Synchronous write, combinational
//               read. Contents are never reset.
// Ports       : clk    - clock, write on rising edge
//               we     - write enable (driven by the mem_stage FSM only)
//               addr   - word index
//               wdata  - write data
//               rdata  - combinational read data at addr
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Combinational read: on a simultaneous read+write the old word is seen.
  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage with a multi-cycle data memory. A load or
//               store holds freeze high while the access FSM walks
//               IDLE -> BUSY (WAIT_CYCLES cycles) -> DONE. The memory is
//               written / the read register loaded on the BUSY->DONE edge.
//               Non-memory instructions pass straight through.
// Ports       : clk           - clock, rising edge
//               rst           - asynchronous active-low reset
//               ALU_res       - effective byte address / ALU result
//               Val_Rm        - store data
//               WB_EN         - write-back enable (passed through)
//               MEM_R_EN      - load request
//               MEM_W_EN      - store request
//               Dest          - destination register (passed through)
//               MEM_result    - load data (read register)
//               ALU_res_out   - combinational copy of ALU_res
//               WB_EN_out     - combinational copy of WB_EN
//               MEM_R_EN_out  - combinational copy of MEM_R_EN
//               Dest_out      - combinational copy of Dest
//               freeze        - stall request to hazard logic / pipeline
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,  // legal 1..15
  parameter int DMEM_BASE   = DMEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_res,
  input  logic [31:0] Val_Rm,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [3:0]  Dest,
  output logic [31:0] MEM_result,
  output logic [31:0] ALU_res_out,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic [3:0]  Dest_out,
  output logic        freeze
);

  localparam logic [CNT_W-1:0] c_wait_m1 = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [7:0]       c_base_lo = 8'(DMEM_BASE);

  mem_state_t           r_state;
  mem_state_t           w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [31:0]          r_rd_data;
  logic                 w_req;
  logic                 w_mem_we;
  logic                 w_rd_load;
  logic [DMEM_AW-1:0]   w_idx;
  logic [31:0]          w_mem_rdata;

  assign w_req = MEM_R_EN | MEM_W_EN;
  assign w_idx = word_index(ALU_res[7:0], c_base_lo);

  // --------------------------------------------------------------------------
  // Pass-through of the pipeline fields
  // --------------------------------------------------------------------------
  assign ALU_res_out  = ALU_res;
  assign WB_EN_out    = WB_EN;
  assign MEM_R_EN_out = MEM_R_EN;
  assign Dest_out     = Dest;

  // Stall for the whole access except the DONE cycle, which lets the
  // pipeline advance with the result already in the read register.
  assign freeze     = w_req & (r_state != DONE);
  assign MEM_result = r_rd_data;

  // --------------------------------------------------------------------------
  // Access FSM: state / counter / read register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_rd_load) begin
        r_rd_data <= w_mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_mem_we     = 1'b0;
    w_rd_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = BUSY;
          w_count_next = c_wait_m1;
        end
      end
      BUSY: begin
        if (!w_req) begin
          // Request withdrawn: abandon the access without side effects.
          w_state_next = IDLE;
          w_count_next = '0;
        end else if (r_count == '0) begin
          w_state_next = DONE;
          w_mem_we     = MEM_W_EN;
          w_rd_load    = MEM_R_EN;
        end else begin
          w_count_next = r_count - 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Data memory
  // --------------------------------------------------------------------------
  data_mem #(
    .DEPTH (DMEM_DEPTH),
    .AW    (DMEM_AW),
    .DW    (32)
  ) u_data_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (w_idx),
    .wdata (Val_Rm),
    .rdata (w_mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. A word-array model of the
//               data memory and the expected load result are kept here and
//               updated from the access rules; each scenario task checks the
//               DUT against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int WAIT = 4;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ALU_res = '0;
  logic [31:0] Val_Rm = '0;
  logic        WB_EN = 1'b0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [3:0]  Dest = '0;
  logic [31:0] MEM_result;
  logic [31:0] ALU_res_out;
  logic        WB_EN_out;
  logic        MEM_R_EN_out;
  logic [3:0]  Dest_out;
  logic        freeze;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [64];
  logic [31:0] exp_res = '0;

  mem_stage #(
    .WAIT_CYCLES (WAIT),
    .DMEM_BASE   (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ALU_res      (ALU_res),
    .Val_Rm       (Val_Rm),
    .WB_EN        (WB_EN),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .Dest         (Dest),
    .MEM_result   (MEM_result),
    .ALU_res_out  (ALU_res_out),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .Dest_out     (Dest_out),
    .freeze       (freeze)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return int'((off / 4) % 64);
  endfunction

  // Present one access at a negedge and count freeze-high cycles until the
  // first freeze-low cycle (DONE). Returns positioned in the DONE cycle.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wd,
                            input logic rd, input logic wr, output int fz);
    bit ok;
    @(negedge clk);
    ALU_res  = addr;
    Val_Rm   = wd;
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    WB_EN    = rd;
    Dest     = 4'($urandom);
    fz = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!freeze) begin
        ok = 1'b1;
        break;
      end
      fz++;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL access_timeout: freeze still high after %0d cycles, expected low after %0d", fz, WAIT + 1);
    end
  endtask

  // Perform an access and update the model from the access rules.
  task automatic model_access(input logic [31:0] addr, input logic [31:0] wd,
                              input logic rd, input logic wr, output int fz);
    int i;
    run_access(addr, wd, rd, wr, fz);
    i = idx_of(addr);
    if (rd) exp_res = model_mem[i];
    if (wr) model_mem[i] = wd;
  endtask

  task automatic go_idle();
    @(negedge clk);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    WB_EN    = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (MEM_result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %08h expected %08h", MEM_result, 32'h0);
    end
    checks++;
    if (freeze !== 1'b0) begin
      errors++; $display("FAIL reset_freeze_idle: got %0b expected 0", freeze);
    end
    MEM_R_EN = 1'b1;
    #1;
    checks++;
    if (freeze !== 1'b1) begin
      errors++; $display("FAIL reset_freeze_req: got %0b expected 1", freeze);
    end
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_res = '0;
  endtask

  task automatic test_prefill();
    int fz;
    for (int i = 0; i < 64; i++) begin
      model_access(32'(BASE + 4 * i), $urandom, 1'b0, 1'b1, fz);
    end
    go_idle();
  endtask

  task automatic test_store_load();
    int fz;
    model_access(32'd1024, 32'hDEADBEEF, 1'b0, 1'b1, fz);
    checks++;
    if (fz !== WAIT + 1) begin
      errors++; $display("FAIL store_freeze: got %0d cycles expected %0d", fz, WAIT + 1);
    end
    model_access(32'd1024, 32'h0, 1'b1, 1'b0, fz);
    checks++;
    if (fz !== WAIT + 1) begin
      errors++; $display("FAIL load_freeze: got %0d cycles expected %0d", fz, WAIT + 1);
    end
    checks++;
    if (MEM_result !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_result: got %08h expected %08h", MEM_result, 32'hDEADBEEF);
    end
    go_idle();
  endtask

  task automatic test_wrap();
    int fz;
    model_access(32'd1028, 32'h11, 1'b0, 1'b1, fz);
    model_access(32'(1024 + 256 + 4), 32'h0, 1'b1, 1'b0, fz);
    checks++;
    if (MEM_result !== 32'h11) begin
      errors++; $display("FAIL wrap_result: got %08h expected %08h", MEM_result, 32'h11);
    end
    go_idle();
  endtask

  task automatic test_passthrough();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ALU_res  = 32'h55;
      WB_EN    = 1'b1;
      Dest     = 4'd3;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      #1;
      checks++;
      if (freeze !== 1'b0 || ALU_res_out !== 32'h55 || Dest_out !== 4'd3 ||
          WB_EN_out !== 1'b1 || MEM_R_EN_out !== 1'b0) begin
        errors++;
        $display("FAIL passthrough: freeze=%0b alu=%08h dest=%0d wb=%0b ren=%0b expected 0/00000055/3/1/0",
                 freeze, ALU_res_out, Dest_out, WB_EN_out, MEM_R_EN_out);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_abort();
    int fz;
    @(negedge clk);                       // IDLE with request
    ALU_res  = 32'd1032;
    Val_Rm   = 32'h22;
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    repeat (3) @(negedge clk);            // 3rd BUSY cycle
    rst      = 1'b0;
    MEM_W_EN = 1'b0;
    exp_res  = '0;
    #1;
    checks++;
    if (MEM_result !== 32'h0 || freeze !== 1'b0) begin
      errors++; $display("FAIL reset_midaccess: result=%08h freeze=%0b expected 00000000/0", MEM_result, freeze);
    end
    @(negedge clk);
    rst = 1'b1;
    model_access(32'd1032, 32'h0, 1'b1, 1'b0, fz);
    checks++;
    if (fz !== WAIT + 1) begin
      errors++; $display("FAIL reset_resume_freeze: got %0d cycles expected %0d", fz, WAIT + 1);
    end
    checks++;
    if (MEM_result !== exp_res || MEM_result === 32'h22) begin
      errors++; $display("FAIL reset_no_write: got %08h expected %08h", MEM_result, exp_res);
    end
    go_idle();
  endtask

  task automatic test_drop_abort();
    int fz;
    logic [31:0] old;
    old = model_mem[idx_of(32'd1040)];
    @(negedge clk);
    ALU_res  = 32'd1040;
    Val_Rm   = ~old;
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    repeat (2) @(negedge clk);            // 2nd BUSY cycle
    MEM_W_EN = 1'b0;
    #1;
    checks++;
    if (freeze !== 1'b0 || MEM_result !== exp_res) begin
      errors++; $display("FAIL drop_abort: freeze=%0b result=%08h expected 0/%08h", freeze, MEM_result, exp_res);
    end
    model_access(32'd1040, 32'h0, 1'b1, 1'b0, fz);
    checks++;
    if (fz !== WAIT + 1 || MEM_result !== old) begin
      errors++; $display("FAIL drop_no_write: cycles=%0d result=%08h expected %0d/%08h", fz, MEM_result, WAIT + 1, old);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int fz1, fz2;
    logic [31:0] r1;
    model_access(32'd1024, 32'h0, 1'b1, 1'b0, fz1);
    r1 = MEM_result;
    checks++;
    if (r1 !== exp_res) begin
      errors++; $display("FAIL b2b_first_result: got %08h expected %08h", r1, exp_res);
    end
    model_access(32'd1028, 32'h0, 1'b1, 1'b0, fz2);
    checks++;
    if (fz1 !== WAIT + 1 || fz2 !== WAIT + 1) begin
      errors++; $display("FAIL b2b_freeze: got %0d,%0d cycles expected %0d,%0d", fz1, fz2, WAIT + 1, WAIT + 1);
    end
    checks++;
    if (MEM_result !== exp_res) begin
      errors++; $display("FAIL b2b_second_result: got %08h expected %08h", MEM_result, exp_res);
    end
    go_idle();
  endtask

  task automatic test_read_write();
    int fz;
    model_access(32'd1036, 32'h33, 1'b0, 1'b1, fz);
    model_access(32'd1036, 32'h77, 1'b1, 1'b1, fz);
    checks++;
    if (MEM_result !== 32'h33) begin
      errors++; $display("FAIL rw_old_word: got %08h expected %08h", MEM_result, 32'h33);
    end
    model_access(32'd1036, 32'h0, 1'b1, 1'b0, fz);
    checks++;
    if (MEM_result !== 32'h77) begin
      errors++; $display("FAIL rw_new_word: got %08h expected %08h", MEM_result, 32'h77);
    end
    go_idle();
  endtask

  task automatic test_random();
    int fz;
    int op;
    logic [31:0] addr;
    logic [3:0]  d;
    for (int n = 0; n < 40; n++) begin
      op   = int'($urandom_range(0, 5));
      addr = 32'(BASE) + $urandom;
      if (op < 2) begin
        d = 4'($urandom);
        @(negedge clk);
        ALU_res  = addr;
        WB_EN    = 1'b1;
        Dest     = d;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        checks++;
        if (freeze !== 1'b0 || ALU_res_out !== addr || Dest_out !== d || MEM_result !== exp_res) begin
          errors++;
          $display("FAIL rand_nop: freeze=%0b alu=%08h dest=%0d result=%08h expected 0/%08h/%0d/%08h",
                   freeze, ALU_res_out, Dest_out, MEM_result, addr, d, exp_res);
        end
      end else begin
        model_access(addr, $urandom, (op != 4), (op >= 4), fz);
        checks++;
        if (fz !== WAIT + 1 || MEM_result !== exp_res) begin
          errors++;
          $display("FAIL rand_access: op=%0d addr=%08h cycles=%0d result=%08h expected %0d/%08h",
                   op, addr, fz, MEM_result, WAIT + 1, exp_res);
        end
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_store_load();
    test_wrap();
    test_passthrough();
    test_reset_abort();
    test_drop_abort();
    test_back_to_back();
    test_read_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
